// File: rtl/irrigation_timer_pkg.sv
// Shared types and digit limits for the irrigation countdown timer.
package irrigation_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2
  } state_t;

  localparam int SEC_UNITS_MAX = 9;
  localparam int SEC_TENS_MAX  = 5;
  localparam int MIN_MAX       = 3;

  localparam int SEC_UNITS_W = 4;
  localparam int SEC_TENS_W  = 3;
  localparam int MIN_W       = 2;

endpackage

// File: rtl/bcd_down_digit.sv
// One decimal-style down-counting digit: wraps 0 -> MAX and flags a borrow.
module bcd_down_digit #(
  parameter int MAX   = 9,
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic [WIDTH-1:0] q,
  output logic             borrow
);

  assign borrow = enable && (q == '0);

  // load has priority so the parent can clear or preset a digit mid-count
  always_ff @(posedge clock) begin
    if (!reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_value;
    end else if (enable) begin
      q <= (q == '0) ? WIDTH'(MAX) : q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/irrigation_countdown.sv
// Minutes/seconds watering countdown: prescaler to a 1 s tick, three cascaded
// down-counting digits, IDLE/RUNNING/PAUSED control and registered pulses.
module irrigation_countdown
  import irrigation_timer_pkg::*;
#(
  parameter int TICKS_PER_SECOND = 1000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic [MIN_W-1:0]       preset_min,
  input  logic [SEC_TENS_W-1:0]  preset_sec_tens,
  input  logic [SEC_UNITS_W-1:0] preset_sec_units,
  output logic [MIN_W-1:0]       min_q,
  output logic [SEC_TENS_W-1:0]  sec_tens_q,
  output logic [SEC_UNITS_W-1:0] sec_units_q,
  output logic                   running,
  output logic                   second_tick,
  output logic                   done,
  output state_t                 fsm_state
);

  localparam int PW = $clog2(TICKS_PER_SECOND);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SECOND - 1);

  state_t          state, state_next;
  logic [PW-1:0]   prescaler, prescaler_next;
  logic            load, dec;
  logic            tick_next, done_next, running_next;
  logic            units_borrow, tens_borrow, min_borrow;

  logic [SEC_UNITS_W-1:0] units_clamped, units_load;
  logic [SEC_TENS_W-1:0]  tens_clamped, tens_load;
  logic [MIN_W-1:0]       min_load;
  logic                   preset_zero, at_last;

  // Clamping happens only on the load path, so digits stay in range.
  assign units_clamped = (preset_sec_units > SEC_UNITS_W'(SEC_UNITS_MAX)) ?
                         SEC_UNITS_W'(SEC_UNITS_MAX) : preset_sec_units;
  assign tens_clamped  = (preset_sec_tens > SEC_TENS_W'(SEC_TENS_MAX)) ?
                         SEC_TENS_W'(SEC_TENS_MAX) : preset_sec_tens;

  assign units_load = abort ? '0 : units_clamped;
  assign tens_load  = abort ? '0 : tens_clamped;
  assign min_load   = (abort || min_borrow) ? '0 : preset_min;

  assign preset_zero = (preset_min == '0) && (tens_clamped == '0) && (units_clamped == '0);
  assign at_last     = (min_q == '0) && (sec_tens_q == '0) && (sec_units_q == SEC_UNITS_W'(1));

  always_comb begin
    state_next     = state;
    prescaler_next = prescaler;
    load           = 1'b0;
    dec            = 1'b0;
    tick_next      = 1'b0;
    done_next      = 1'b0;
    if (abort) begin
      state_next     = IDLE;
      load           = 1'b1;
      prescaler_next = '0;
    end else if (start) begin
      load           = 1'b1;
      prescaler_next = '0;
      if (preset_zero) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = RUNNING;
      end
    end else begin
      unique case (state)
        RUNNING, PAUSED: begin
          if (pause) begin
            state_next = PAUSED;
          end else begin
            // The edge that leaves PAUSED already counts, so each paused edge costs one cycle.
            state_next = RUNNING;
            if (prescaler == PRE_LAST) begin
              prescaler_next = '0;
              dec            = 1'b1;
              tick_next      = 1'b1;
              if (at_last) begin
                state_next = IDLE;
                done_next  = 1'b1;
              end
            end else begin
              prescaler_next = prescaler + PW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign running_next = (state_next != IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      prescaler   <= '0;
      running     <= 1'b0;
      second_tick <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      prescaler   <= prescaler_next;
      running     <= running_next;
      second_tick <= tick_next;
      done        <= done_next;
    end
  end

  assign fsm_state = state;

  bcd_down_digit #(.MAX(SEC_UNITS_MAX), .WIDTH(SEC_UNITS_W)) u_units (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (units_load),
    .enable     (dec),
    .q          (sec_units_q),
    .borrow     (units_borrow)
  );

  bcd_down_digit #(.MAX(SEC_TENS_MAX), .WIDTH(SEC_TENS_W)) u_tens (
    .clock      (clock),
    .reset      (reset),
    .load       (load),
    .load_value (tens_load),
    .enable     (units_borrow),
    .q          (sec_tens_q),
    .borrow     (tens_borrow)
  );

  // A borrow out of minutes is pinned back to zero instead of wrapping.
  bcd_down_digit #(.MAX(MIN_MAX), .WIDTH(MIN_W)) u_min (
    .clock      (clock),
    .reset      (reset),
    .load       (load || min_borrow),
    .load_value (min_load),
    .enable     (tens_borrow),
    .q          (min_q),
    .borrow     (min_borrow)
  );

endmodule

// File: tb/tb_irrigation_countdown.sv
// Bench for irrigation_countdown: a seconds-level reference model queues expected
// tick/done events; a negedge monitor pops and compares them as they appear.
module tb_irrigation_countdown;
  import irrigation_timer_pkg::*;

  localparam int T  = 4;
  localparam int EW = 44;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] preset_min = '0;
  logic [2:0] preset_sec_tens = '0;
  logic [3:0] preset_sec_units = '0;
  logic [1:0] min_q;
  logic [2:0] sec_tens_q;
  logic [3:0] sec_units_q;
  logic       running, second_tick, done;
  state_t     fsm_state;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] mon_act, mon_exp;

  irrigation_countdown #(.TICKS_PER_SECOND(T)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .pause            (pause),
    .abort            (abort),
    .preset_min       (preset_min),
    .preset_sec_tens  (preset_sec_tens),
    .preset_sec_units (preset_sec_units),
    .min_q            (min_q),
    .sec_tens_q       (sec_tens_q),
    .sec_units_q      (sec_units_q),
    .running          (running),
    .second_tick      (second_tick),
    .done             (done),
    .fsm_state        (fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Event record: {edge, done, tick, running, min, tens, units}; r = seconds remaining.
  function automatic logic [EW-1:0] pack_ev(input int e, input bit d, input bit tk, input int r);
    logic [31:0] e32;
    e32 = e;
    return {e32, d, tk, ~d, 2'(r / 60), 3'((r % 60) / 10), 4'(r % 10)};
  endfunction

  // Reference model: walk edges after the start edge, count the non-paused ones,
  // and every T of them one second elapses. Abort cuts off everything from its edge.
  task automatic build_events(input int e0, input int n, input int ps, input int pl, input int ab);
    int e, c, k;
    if (n == 0) begin
      exp_q.push_back(pack_ev(e0, 1'b1, 1'b0, 0));
      return;
    end
    e = e0;
    c = 0;
    k = 0;
    while (k < n) begin
      e++;
      if (ab != 0 && e >= ab) break;
      if (!(e >= ps && e < ps + pl)) begin
        c++;
        if (c % T == 0) begin
          k++;
          exp_q.push_back(pack_ev(e, k == n, 1'b1, n - k));
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (reset && (second_tick || done)) begin
      mon_act = {32'(edge_cnt), done, second_tick, running, min_q, sec_tens_q, sec_units_q};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected output %0h", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL event: got %0h expected %0h", mon_act, mon_exp);
        end
      end
    end
  end

  // driver: one countdown, optionally with a pause window or an abort
  task automatic do_run(input int m, input int t, input int u,
                        input int ps_off, input int pl, input int ab_off);
    int e0, n, tc, uc, budget;
    logic [8:0] snap;
    tc = (t > 5) ? 5 : t;
    uc = (u > 9) ? 9 : u;
    n  = m * 60 + tc * 10 + uc;
    @(negedge clock);
    preset_min       = 2'(m);
    preset_sec_tens  = 3'(t);
    preset_sec_units = 4'(u);
    start = 1'b1;
    e0 = edge_cnt + 1;
    build_events(e0, n, (pl > 0) ? e0 + ps_off : 0, pl, (ab_off > 0) ? e0 + ab_off : 0);
    @(negedge clock);
    start = 1'b0;
    if (n == 0) begin
      check("zero_running", 64'(running), 64'(0));
      check("zero_digits", 64'({min_q, sec_tens_q, sec_units_q}), 64'(0));
    end else begin
      check("load_digits", 64'({min_q, sec_tens_q, sec_units_q}), 64'({2'(m), 3'(tc), 4'(uc)}));
      check("load_running", 64'(running), 64'(1));
    end
    if (pl > 0) begin
      while (edge_cnt != e0 + ps_off - 1) @(negedge clock);
      snap  = {min_q, sec_tens_q, sec_units_q};
      pause = 1'b1;
      for (int i = 0; i < pl; i++) begin
        @(negedge clock);
        check("pause_frozen", 64'({min_q, sec_tens_q, sec_units_q}), 64'(snap));
      end
      pause = 1'b0;
    end
    if (ab_off > 0) begin
      while (edge_cnt != e0 + ab_off - 1) @(negedge clock);
      abort = 1'b1;
      start = 1'b1;
      @(negedge clock);
      abort = 1'b0;
      start = 1'b0;
      check("abort_digits", 64'({min_q, sec_tens_q, sec_units_q}), 64'(0));
      check("abort_running", 64'(running), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      check("abort_state", 64'(fsm_state), 64'(IDLE));
    end
    budget = n * T + pl + 20;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected events still pending after %0d cycles", exp_q.size(), budget);
      exp_q.delete();
    end
    repeat (4) @(negedge clock);
    check("idle_running", 64'(running), 64'(0));
    check("idle_state", 64'(fsm_state), 64'(IDLE));
  endtask

  initial begin
    int m, t, u, n, mode;
    // reset wins over a concurrent start
    reset = 1'b0;
    start = 1'b1;
    preset_min = 2'd3; preset_sec_tens = 3'd5; preset_sec_units = 4'd9;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_digits", 64'({min_q, sec_tens_q, sec_units_q}), 64'(0));
    check("reset_running", 64'(running), 64'(0));
    check("reset_tick", 64'(second_tick), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_state", 64'(fsm_state), 64'(IDLE));
    start = 1'b0;
    reset = 1'b1;
    repeat (5) @(negedge clock);
    check("post_reset_done", 64'(done), 64'(0));
    check("post_reset_running", 64'(running), 64'(0));

    do_run(0, 0, 3, 0, 0, 0);
    do_run(1, 0, 0, 0, 0, 0);
    do_run(0, 1, 0, 15, 10, 0);
    do_run(0, 2, 5, 0, 0, 30);
    do_run(0, 7, 12, 0, 0, 0);
    do_run(0, 0, 0, 0, 0, 0);

    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(1, 0);
      t = $urandom_range(7, 0);
      u = $urandom_range(15, 0);
      n = m * 60 + ((t > 5) ? 5 : t) * 10 + ((u > 9) ? 9 : u);
      mode = (n == 0) ? 0 : $urandom_range(2, 0);
      if (mode == 1)
        do_run(m, t, u, $urandom_range(n * T - 2, 2), $urandom_range(12, 1), 0);
      else if (mode == 2)
        do_run(m, t, u, 0, 0, $urandom_range(n * T, 2));
      else
        do_run(m, t, u, 0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
